gray_counter: RTL and testbench

Registered up/down counter that emits a WIDTH-bit Gray code and its binary equivalent from the same edge. It is the source stage for the gray-to-binary decoder: its `gray` output drives the decoder input, and its `binary` output is the golden check value for that decoder. It also serves as the pointer generator for Gray-coded FIFO pointers. Loadable, with an optional saturating mode and a wrap pulse.

---
 rtl/gray_counter.sv | 69 ++++++
 tb/tb_gray_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Loadable up/down binary counter with registered Gray-code output, optional
// saturation and a one-cycle wrap pulse. Usable as a Gray FIFO pointer source.
module gray_counter #(
  parameter int unsigned WIDTH    = 5,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] next_bin_c;
  logic             next_wrap_c;
  logic             at_max_c;
  logic             at_zero_c;

  assign at_max_c  = (binary == MAX_VAL);
  assign at_zero_c = (binary == '0);

  // Next count: load beats count, count beats hold; ends either wrap or stick.
  always_comb begin
    next_bin_c  = binary;
    next_wrap_c = 1'b0;
    if (load) begin
      next_bin_c = load_val;
    end else if (en && up) begin
      if (at_max_c) begin
        if (!SATURATE) begin
          next_bin_c  = '0;
          next_wrap_c = 1'b1;
        end
      end else begin
        next_bin_c = binary + ONE;
      end
    end else if (en) begin
      if (at_zero_c) begin
        if (!SATURATE) begin
          next_bin_c  = MAX_VAL;
          next_wrap_c = 1'b1;
        end
      end else begin
        next_bin_c = binary - ONE;
      end
    end
  end

  // Binary and Gray registers update together so they always describe one count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary <= '0;
      gray   <= '0;
      wrap   <= 1'b0;
    end else begin
      binary <= next_bin_c;
      gray   <= next_bin_c ^ (next_bin_c >> 1);
      wrap   <= next_wrap_c;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: a wrapping and a saturating instance share
// stimulus; per-instance expected results go through scoreboard queues.
module tb_gray_counter;

  localparam int unsigned W = 5;

  typedef struct packed {
    logic [W-1:0] b;
    logic         w;
  } exp_t;

  logic         clk = 1'b0;
  logic         clk_run = 1'b1;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] gray0, binary0, gray1, binary1;
  logic         wrap0, wrap1;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  gray_counter #(.WIDTH(W), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray(gray0), .binary(binary0), .wrap(wrap0)
  );

  gray_counter #(.WIDTH(W), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray(gray1), .binary(binary1), .wrap(wrap1)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference decoder: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    r[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic exp_t model(input exp_t cur, input bit sat, input logic e,
                                 input logic u, input logic l, input logic [W-1:0] lv);
    exp_t r;
    int   v;
    int   n;
    r.b = cur.b;
    r.w = 1'b0;
    v = int'(cur.b);
    if (l) begin
      r.b = lv;
    end else if (e) begin
      n = u ? v + 1 : v - 1;
      if (n < 0 || n >= (1 << W)) begin
        if (!sat) begin
          r.b = W'((n + (1 << W)) % (1 << W));
          r.w = 1'b1;
        end
      end else begin
        r.b = W'(n);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, push expectations, compare after the rising edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    exp_t         x0, x1;
    logic [W-1:0] prev_g0;
    prev_g0 = gray0;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    m0 = model(m0, 1'b0, e, u, l, lv);
    m1 = model(m1, 1'b1, e, u, l, lv);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x0 = q0.pop_front();
      x1 = q1.pop_front();
      chk("wrap_binary", binary0, x0.b);
      chk("wrap_gray", gray0, to_gray(x0.b));
      chk("wrap_pulse", W'(wrap0), W'(x0.w));
      chk("sat_binary", binary1, x1.b);
      chk("sat_gray", gray1, to_gray(x1.b));
      chk("sat_pulse", W'(wrap1), W'(x1.w));
      chk("decoder", g2b(gray0), binary0);
      if (e && !l) chk("one_bit_change", W'($countones(gray0 ^ prev_g0)), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] hold_b;
    m0 = '0;
    m1 = '0;

    #12;
    chk("reset_gray", gray0, '0);
    chk("reset_binary", binary0, '0);
    chk("reset_wrap", W'(wrap0), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count a little, then reset with the clock stopped.
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    clk_run = 1'b0;
    en = 1'b1; up = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gray", gray0, '0);
    chk("async_rst_binary", binary0, '0);
    chk("async_rst_wrap", W'(wrap0), '0);
    chk("async_rst_sat_binary", binary1, '0);
    q0.delete();
    q1.delete();
    m0 = '0;
    m1 = '0;
    #2 rst_n = 1'b1;
    en = 1'b0;
    clk_run = 1'b1;

    step(1'b1, 1'b1, 1'b0, '0); chk("seq1", gray0, 5'b00001);
    step(1'b1, 1'b1, 1'b0, '0); chk("seq2", gray0, 5'b00011);
    step(1'b1, 1'b1, 1'b0, '0); chk("seq3", gray0, 5'b00010);
    step(1'b1, 1'b1, 1'b0, '0); chk("seq4", gray0, 5'b00110);

    // Load, and load beating a simultaneous count.
    step(1'b0, 1'b0, 1'b1, 5'b01110); chk("load_gray", gray0, 5'b01001);
    step(1'b1, 1'b1, 1'b1, 5'b10110);
    chk("load_en_binary", binary0, 5'b10110);
    chk("load_en_gray", gray0, 5'b11101);

    // Wrap up then wrap down.
    step(1'b0, 1'b0, 1'b1, 5'b11111);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_up_gray", gray0, 5'b00000);
    chk("wrap_up_pulse", W'(wrap0), W'(1));
    step(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pulse_drop", W'(wrap0), W'(0));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_dn_binary", binary0, 5'b11111);
    chk("wrap_dn_gray", gray0, 5'b10000);
    chk("wrap_dn_pulse", W'(wrap0), W'(1));

    // Saturating instance sticks at both ends.
    step(1'b0, 1'b0, 1'b1, 5'b11111);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    chk("sat_top_binary", binary1, 5'b11111);
    chk("sat_top_gray", gray1, 5'b10000);
    step(1'b0, 1'b0, 1'b1, 5'b00000);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    chk("sat_bot_binary", binary1, 5'b00000);

    // Full sweep in both directions.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, '0);

    // Hold with a wandering direction bit.
    step(1'b0, 1'b0, 1'b1, 5'b01011);
    hold_b = binary0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'b0, 5'($urandom_range(31)));
      chk("hold_binary", binary0, hold_b);
      chk("hold_wrap", W'(wrap0), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
